// File: rtl/rv_instr_field_decoder.sv
// RV32I instruction field splitter: a single instruction register whose fixed-position
// fields and sign-extended I/S immediates are presented combinationally in parallel.
module rv_instr_field_decoder (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwLoad,
    input  logic [31:0] iwInstr,
    output logic [6:0]  owOpCode,
    output logic [4:0]  owRd,
    output logic [2:0]  owFunct3,
    output logic [4:0]  owRs1,
    output logic [4:0]  owRs2,
    output logic [6:0]  owFunct7,
    output logic [19:0] owImmediate20,
    output logic [11:0] owImmediate12,
    output logic [11:0] owImmediate12SClass,
    output logic [31:0] owImmediate12Extended,
    output logic [31:0] owImmediate12SClassExtended
);

    logic [31:0] instr_reg;

    function automatic logic [31:0] sign_extend_12(input logic [11:0] value);
        return {{20{value[11]}}, value};
    endfunction

    // NOTE: registered state is written with non-blocking assignments so every reader
    // sees the pre-edge value; the async reset clears it without waiting for a clock.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            instr_reg <= '0;
        end else if (iwLoad) begin
            instr_reg <= iwInstr;
        end
    end

    // Extraction is purely positional; opcode never gates which fields are produced.
    assign owOpCode            = instr_reg[6:0];
    assign owRd                = instr_reg[11:7];
    assign owFunct3            = instr_reg[14:12];
    assign owRs1               = instr_reg[19:15];
    assign owRs2               = instr_reg[24:20];
    assign owFunct7            = instr_reg[31:25];
    assign owImmediate20       = instr_reg[31:12];
    assign owImmediate12       = instr_reg[31:20];
    assign owImmediate12SClass = {instr_reg[31:25], instr_reg[11:7]};

    assign owImmediate12Extended       = sign_extend_12(owImmediate12);
    assign owImmediate12SClassExtended = sign_extend_12(owImmediate12SClass);

endmodule

// File: tb/tb_rv_instr_field_decoder.sv
// Scoreboard bench: stimulus pushes the expected field set after each edge; a negedge
// monitor pops and compares, against a reference model built from plain arithmetic.
module tb_rv_instr_field_decoder;

    logic        iwClk;
    logic        iwnRst;
    logic        iwLoad;
    logic [31:0] iwInstr;
    logic [6:0]  owOpCode;
    logic [4:0]  owRd;
    logic [2:0]  owFunct3;
    logic [4:0]  owRs1;
    logic [4:0]  owRs2;
    logic [6:0]  owFunct7;
    logic [19:0] owImmediate20;
    logic [11:0] owImmediate12;
    logic [11:0] owImmediate12SClass;
    logic [31:0] owImmediate12Extended;
    logic [31:0] owImmediate12SClassExtended;

    rv_instr_field_decoder dut (
        .iwClk                       (iwClk),
        .iwnRst                      (iwnRst),
        .iwLoad                      (iwLoad),
        .iwInstr                     (iwInstr),
        .owOpCode                    (owOpCode),
        .owRd                        (owRd),
        .owFunct3                    (owFunct3),
        .owRs1                       (owRs1),
        .owRs2                       (owRs2),
        .owFunct7                    (owFunct7),
        .owImmediate20               (owImmediate20),
        .owImmediate12               (owImmediate12),
        .owImmediate12SClass         (owImmediate12SClass),
        .owImmediate12Extended       (owImmediate12Extended),
        .owImmediate12SClassExtended (owImmediate12SClassExtended)
    );

    initial iwClk = 1'b0;
    always #5 iwClk = ~iwClk;

    typedef struct {
        int unsigned opcode;
        int unsigned rd;
        int unsigned funct3;
        int unsigned rs1;
        int unsigned rs2;
        int unsigned funct7;
        int unsigned imm20;
        int unsigned imm12;
        int unsigned imm12s;
        int unsigned imm12_ext;
        int unsigned imm12s_ext;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned model_ir;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference: fields by division/modulo, sign extension as "subtract 4096 if negative".
    function automatic int unsigned sext12(input int unsigned v);
        return (v >= 2048) ? (v - 4096) : v;
    endfunction

    function automatic exp_t model(input int unsigned ir);
        exp_t e;
        e.opcode     = ir % 128;
        e.rd         = (ir / 128) % 32;
        e.funct3     = (ir / 4096) % 8;
        e.rs1        = (ir / 32768) % 32;
        e.rs2        = (ir / 1048576) % 32;
        e.funct7     = ir / 33554432;
        e.imm20      = ir / 4096;
        e.imm12      = ir / 1048576;
        e.imm12s     = e.funct7 * 32 + e.rd;
        e.imm12_ext  = sext12(e.imm12);
        e.imm12s_ext = sext12(e.imm12s);
        return e;
    endfunction

    task automatic compare_outputs(input exp_t e, input string tag);
        check({tag, ".opcode"},     32'(owOpCode),                    e.opcode);
        check({tag, ".rd"},         32'(owRd),                        e.rd);
        check({tag, ".funct3"},     32'(owFunct3),                    e.funct3);
        check({tag, ".rs1"},        32'(owRs1),                       e.rs1);
        check({tag, ".rs2"},        32'(owRs2),                       e.rs2);
        check({tag, ".funct7"},     32'(owFunct7),                    e.funct7);
        check({tag, ".imm20"},      32'(owImmediate20),               e.imm20);
        check({tag, ".imm12"},      32'(owImmediate12),               e.imm12);
        check({tag, ".imm12s"},     32'(owImmediate12SClass),         e.imm12s);
        check({tag, ".imm12_ext"},  owImmediate12Extended,            e.imm12_ext);
        check({tag, ".imm12s_ext"}, owImmediate12SClassExtended,      e.imm12s_ext);
    endtask

    // Monitor: the register settles after the posedge; compare away from it.
    initial begin
        exp_t e;
        forever begin
            @(negedge iwClk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare_outputs(e, "mon");
            end
        end
    end

    // Drive inputs for one edge, then record what the DUT must show after it.
    task automatic cycle(input logic load, input logic [31:0] instr);
        iwLoad  = load;
        iwInstr = instr;
        @(posedge iwClk);
        if (load) model_ir = instr;
        #1;
        exp_q.push_back(model(model_ir));
    endtask

    exp_t zero_exp;
    exp_t held;
    logic [31:0] prev_ext_hi;

    initial begin
        zero_exp = model(0);
        model_ir = 0;
        iwnRst   = 1'b0;
        iwLoad   = 1'b1;
        iwInstr  = 32'hFFF10093;
        repeat (2) @(posedge iwClk);
        #1;
        compare_outputs(zero_exp, "reset_dominates_load");
        iwnRst = 1'b1;

        // ADDI x1,x2,-1
        cycle(1'b1, 32'hFFF10093);
        check("addi.opcode",  32'(owOpCode), 32'h13);
        check("addi.rd",      32'(owRd), 32'd1);
        check("addi.rs1",     32'(owRs1), 32'd2);
        check("addi.imm12",   32'(owImmediate12), 32'hFFF);
        check("addi.imm_ext", owImmediate12Extended, 32'hFFFFFFFF);

        // SW x5,8(x6)
        cycle(1'b1, 32'h00532423);
        check("sw.funct3",     32'(owFunct3), 32'd2);
        check("sw.rs2",        32'(owRs2), 32'd5);
        check("sw.imm12s",     32'(owImmediate12SClass), 32'h008);
        check("sw.imm12s_ext", owImmediate12SClassExtended, 32'h00000008);
        check("sw.imm12",      32'(owImmediate12), 32'h005);

        // Hold: input noise with load low must not disturb the register
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'hFFFFFFFF);
            check("hold.imm12s", 32'(owImmediate12SClass), 32'h008);
        end

        // LUI then SUB back to back
        cycle(1'b1, 32'h123451B7);
        check("lui.imm20", 32'(owImmediate20), 32'h12345);
        check("lui.rd",    32'(owRd), 32'd3);
        cycle(1'b1, 32'h40628233);
        check("sub.funct7", 32'(owFunct7), 32'h20);
        check("sub.opcode", 32'(owOpCode), 32'h33);

        // Sign boundaries; the two extended immediates share their upper bits
        cycle(1'b1, 32'h80000013);
        check("sign_neg.ext", owImmediate12Extended, 32'hFFFFF800);
        check("sign_neg.hi",  32'(owImmediate12SClassExtended[31:12]), 32'(owImmediate12Extended[31:12]) & 32'hFFFFF);
        prev_ext_hi = 32'(owImmediate12Extended[31:12]);
        check("sign_neg.hi_const", prev_ext_hi, 32'hFFFFF);
        cycle(1'b1, 32'h7FF00013);
        check("sign_pos.ext", owImmediate12Extended, 32'h000007FF);
        check("sign_pos.s_hi", 32'(owImmediate12SClassExtended[31:12]), 32'h0);

        // Async reset between edges with an instruction held
        cycle(1'b1, 32'hFFF10093);
        @(negedge iwClk);
        #1 iwnRst = 1'b0;
        #1 compare_outputs(zero_exp, "async_reset");
        model_ir = 0;
        iwLoad  = 1'b1;
        iwInstr = 32'h00532423;
        #1 iwnRst = 1'b1;
        cycle(1'b1, 32'h00532423);
        check("post_reset.rs1",    32'(owRs1), 32'd6);
        check("post_reset.opcode", 32'(owOpCode), 32'h23);

        // Randomized traffic, including held loads and idle cycles
        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[31] = 1'b1;
            cycle(($urandom_range(0, 3) != 0), r);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge iwClk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
